// File: rtl/fir_pkg.sv
// fir_pkg: types and default sizing shared by the FIR address sequencer, sample mux and MAC.
package fir_pkg;

  localparam int FIR_ADDR_WIDTH = 13;
  localparam int FIR_TAPS       = 32;
  localparam int FIR_RD_LAT     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fir_state_e;

  // first/last are only ever set together with valid
  typedef struct packed {
    logic                      valid;
    logic                      first;
    logic                      last;
    logic [FIR_ADDR_WIDTH-1:0] n;
  } fir_tag_t;

endpackage

// File: rtl/fir_tag_pipe.sv
// fir_tag_pipe: DEPTH-stage shift register carrying MAC tags alongside the memory read latency.
module fir_tag_pipe
  import fir_pkg::*;
#(
  parameter int DEPTH = FIR_RD_LAT,
  parameter int W     = $bits(fir_tag_t)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [W-1:0] tag_in,
  output logic [W-1:0] tag_out
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  // Shift one stage per cycle; stage 0 takes the new tag.
  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage flops; reset and flush both empty the pipe.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/fir_addr_seq.sv
// fir_addr_seq: FIR pass sequencer driving sample/coef addresses, MAC control and result strobes.
// Optional abort input / aborted pulse are present when FIR_ADDR_SEQ_ABORT_EN is defined.
module fir_addr_seq
  import fir_pkg::*;
#(
  parameter int  ADDR_WIDTH = FIR_ADDR_WIDTH,
  parameter int  TAPS       = FIR_TAPS,
  parameter int  RD_LAT     = FIR_RD_LAT,
  localparam int CW         = $clog2(TAPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] n_samples,
  output logic                  fsm_mux,
  output logic [ADDR_WIDTH-1:0] a_probka_fir,
  output logic [CW-1:0]         coef_addr,
  output logic                  mac_clr,
  output logic                  mac_en,
  output logic                  y_we,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic                  busy,
  output logic                  done
`ifdef FIR_ADDR_SEQ_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  aborted
`endif
);

  localparam logic [ADDR_WIDTH-1:0] KMAX_CAP = ADDR_WIDTH'(TAPS - 1);

  fir_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic [ADDR_WIDTH-1:0] n_last_q, n_last_d;
  logic [CW-1:0]         k_q, k_d;
  logic [CW-1:0]         kmax_s;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [CW-1:0]         coef_q, coef_d;
  logic                  y_we_q, y_we_d;
  logic [ADDR_WIDTH-1:0] y_addr_q, y_addr_d;
  logic                  fsm_mux_q, fsm_mux_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  abort_hit_s;
  logic                  run_next_s;
  fir_tag_t              tag_in_s, tag_out_s;
`ifdef FIR_ADDR_SEQ_ABORT_EN
  logic                  aborted_q, aborted_d;
`endif

  // Next state, tap/sample counters and the next value of every registered output.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    n_last_d    = n_last_q;
    abort_hit_s = 1'b0;
    // Early outputs have fewer than TAPS history samples; clamp so n-k never goes below 0.
    kmax_s      = (n_q < KMAX_CAP) ? n_q[CW-1:0] : CW'(TAPS - 1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (n_samples != '0) begin
            state_d  = ST_RUN;
            n_d      = '0;
            k_d      = '0;
            n_last_d = n_samples - ADDR_WIDTH'(1);
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (k_q == kmax_s) begin
          k_d = '0;
          if (n_q == n_last_q) begin
            state_d = ST_DRAIN;
          end else begin
            n_d = n_q + ADDR_WIDTH'(1);
          end
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (y_we_q && (y_addr_q == n_last_q)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef FIR_ADDR_SEQ_ABORT_EN
    if (abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN))) begin
      abort_hit_s = 1'b1;
      state_d     = ST_IDLE;
    end else begin
      abort_hit_s = 1'b0;
    end
    aborted_d = abort_hit_s;
`endif

    tag_in_s = '0;
    if (state_q == ST_RUN) begin
      tag_in_s.valid = 1'b1;
      tag_in_s.first = (k_q == '0);
      tag_in_s.last  = (k_q == kmax_s);
      tag_in_s.n     = FIR_ADDR_WIDTH'(n_q);
    end else begin
      tag_in_s = '0;
    end

    run_next_s = (state_d == ST_RUN);
    a_d        = run_next_s ? (n_d - ADDR_WIDTH'(k_d)) : '0;
    coef_d     = run_next_s ? k_d : '0;
    y_we_d     = tag_out_s.last & ~abort_hit_s;
    y_addr_d   = y_we_d ? ADDR_WIDTH'(tag_out_s.n) : '0;
    fsm_mux_d  = (state_d != ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // State, counter and output flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      k_q       <= '0;
      n_last_q  <= '0;
      a_q       <= '0;
      coef_q    <= '0;
      y_we_q    <= 1'b0;
      y_addr_q  <= '0;
      fsm_mux_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef FIR_ADDR_SEQ_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      k_q       <= k_d;
      n_last_q  <= n_last_d;
      a_q       <= a_d;
      coef_q    <= coef_d;
      y_we_q    <= y_we_d;
      y_addr_q  <= y_addr_d;
      fsm_mux_q <= fsm_mux_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef FIR_ADDR_SEQ_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  fir_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (abort_hit_s),
    .tag_in  (tag_in_s),
    .tag_out (tag_out_s)
  );

  assign fsm_mux      = fsm_mux_q;
  assign a_probka_fir = a_q;
  assign coef_addr    = coef_q;
  assign mac_en       = tag_out_s.valid;
  assign mac_clr      = tag_out_s.first;
  assign y_we         = y_we_q;
  assign y_addr       = y_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
`ifdef FIR_ADDR_SEQ_ABORT_EN
  assign aborted      = aborted_q;
`endif

endmodule

// File: doc/fir_addr_seq.md
Name: fir_addr_seq

Overview:
- Control sequencer directly upstream of the sample-memory address mux.
- Owns the FIR pass. Drives the mux select `fsm_mux`: 0 = AXI owns memory, 1 = FIR owns it.
- Generates sample read addresses `a_probka_fir`, coefficient addresses and MAC control.
- Emits output write strobes, plus a start/busy/done handshake toward the AXI register block.

Parameters:
- ADDR_WIDTH, 13, width of sample/result addresses (matches the mux WIDTH).
- TAPS, 32, number of FIR coefficients; must be >= 2.
- RD_LAT, 2, cycles from address issue to operand valid at the MAC (mux register + RAM read).
- CW, $clog2(TAPS), coefficient address width (derived; not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to begin a pass; honoured only in IDLE.
- n_samples  in  ADDR_WIDTH  number of input samples; sampled on the accepted start.
- fsm_mux  out  1  mux select: 0 = AXI address, 1 = FIR address.
- a_probka_fir  out  ADDR_WIDTH  sample read address (n-k).
- coef_addr  out  CW  coefficient read address (k), aligned with a_probka_fir.
- mac_clr  out  1  accumulator loads the product instead of adding; coincident with the first mac_en of each output.
- mac_en  out  1  MAC operands valid this cycle.
- y_we  out  1  result write strobe, one cycle per output sample.
- y_addr  out  ADDR_WIDTH  result address n, valid with y_we.
- busy  out  1  high from the cycle after the accepted start through the done cycle.
- done  out  1  single-cycle pass-complete pulse.

Behaviour:
- Reset, rst_n=0 at a clock edge: state=IDLE. All outputs 0. Tag pipeline flushed. Mid-pass reset aborts with no y_we and no done.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start=1 with n_samples!=0: latch n_samples, set n=0, k=0, go to RUN. fsm_mux and busy rise at the next edge.
  - On start=1 with n_samples=0: go to DONE directly; no reads, no writes.
- RUN, one issue per cycle:
  - a_probka_fir = n-k, coef_addr = k.
  - Tap loop runs k = 0..kmax with kmax = min(n, TAPS-1), i.e. no reads below address 0.
  - At k==kmax: k←0, n←n+1.
  - At k==kmax with n==n_samples-1: go to DRAIN.
  - Steady state is TAPS cycles per output. Total issue cycles = Σ min(n+1, TAPS).
- Tag pipeline: each issue pushes {valid, first=(k==0), last=(k==kmax), n} into an RD_LAT-deep shift register.
  - At the output: mac_en=valid, mac_clr=valid&first.
  - One cycle after a last tag pops: y_we=1, y_addr=its n.
- DRAIN: hold fsm_mux=1 while the pipeline empties. Go to DONE in the cycle the final y_we is asserted.
- DONE: done=1, busy=1, fsm_mux=1 for one cycle; then IDLE with fsm_mux=0 and busy=0.
- Latency: done pulses exactly RD_LAT+2 cycles after the last RUN issue cycle.
- Outputs when not issuing: a_probka_fir and coef_addr held at 0 outside RUN.
- start while busy: ignored; no queueing.
- start coincident with the DONE cycle: ignored.
- Arithmetic: n-k never underflows (k<=n by construction). n counter is ADDR_WIDTH bits. n_samples up to 2^ADDR_WIDTH-1.

Optional Feature:
- Macro: FIR_ADDR_SEQ_ABORT_EN.
- Defined:
  - Adds input `abort` (1 bit) and output `aborted` (1-cycle pulse).
  - abort=1 in RUN or DRAIN: next edge goes to IDLE, flushes the tag pipeline, suppresses further mac_en/y_we, drops fsm_mux.
  - aborted pulses in that cycle; done is not asserted.
  - abort is ignored in IDLE and DONE.
- Undefined: neither port exists; a pass always runs to completion.

Decomposition:
- Shared package fir_pkg:
  - state enum (IDLE/RUN/DRAIN/DONE);
  - tag struct {valid, first, last, n};
  - default ADDR_WIDTH/TAPS/RD_LAT localparams, shared with the mux and MAC.
- One natural sub-module: fir_tag_pipe, a parameterised RD_LAT-stage shift register of the tag struct with synchronous flush.

Test Plan:
- TAPS=4, RD_LAT=2, n_samples=3, start pulse -> exactly 6 issue cycles with addresses 0 | 1,0 | 2,1,0.
  - mac_clr on the 1st, 2nd and 4th mac_en.
  - y_we at y_addr 0,1,2.
  - done 4 cycles after the last issue; fsm_mux=0 afterwards.
- n_samples=10, TAPS=4 -> steady state shows 4 issues per output (n=3: addresses 3,2,1,0). Total issue cycles 34; 10 y_we pulses.
- start with n_samples=0 -> done one cycle later; no mac_en or y_we; fsm_mux never high for more than that cycle.
- start re-asserted during RUN with a different n_samples -> ignored; original pass completes unchanged.
- rst_n=0 mid-RUN for one cycle -> next cycle all outputs 0 and IDLE; no y_we or done from the killed pass; a fresh start then runs normally.
- With FIR_ADDR_SEQ_ABORT_EN: abort during DRAIN -> aborted pulse, no further y_we, no done, fsm_mux=0 the next cycle.
